// File: rtl/mac_seq_pkg.sv
// ----------------------------------------------------------------------------
// mac_seq_pkg
// Shared types and constants for the MAC dot-product sequencer.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mac_seq_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  // Sequencer control states.
  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } seq_state_e;

  // Return signed byte lane k of a packed 4-lane operand word.
  function automatic logic signed [LANE_W-1:0] lane_get(
    input logic [LANES*LANE_W-1:0] word,
    input int unsigned             k
  );
    return LANE_W'(word >> (k * LANE_W));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_tag_pipe.sv
// ----------------------------------------------------------------------------
// mac_tag_pipe
// Latency-matched valid shift register that tags beats in flight through
// the MAC unit; clears synchronously so stale results are ignored.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_tag_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic push_i,
  output logic tail_o,
  output logic any_o
);

  logic [DEPTH-1:0] tag_q;
  logic [DEPTH-1:0] tag_d;

  generate
    if (DEPTH == 1) begin : g_single
      assign tag_d = push_i;
    end else begin : g_multi
      assign tag_d = {tag_q[DEPTH-2:0], push_i};
    end
  endgenerate

  // Advance the tag chain one stage per cycle; reset drops every tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tail_o = tag_q[DEPTH-1];
  assign any_o  = |tag_q;

endmodule

`default_nettype wire

// File: rtl/mac_dot_sequencer.sv
// ----------------------------------------------------------------------------
// mac_dot_sequencer
// Feeds a fixed-latency 4-lane signed MAC, accumulates returning partial
// sums over an in_last-terminated group and hands out one result per group.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_dot_sequencer
  import mac_seq_pkg::*;
#(
  parameter int MAC_LATENCY = 3,
  parameter int ACC_W       = 32,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_dataa,
  input  logic [31:0]      in_datab,
  input  logic             in_last,
  output logic [31:0]      mac_dataa,
  output logic [31:0]      mac_datab,
  input  logic [31:0]      mac_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_result,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  seq_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;
  logic             retire;
  logic             in_flight;

  // Ready depends only on state (and is forced low while in reset).
  assign in_ready = (state_q == ACCUM) && !reset;
  assign accept   = in_valid && in_ready;

  // Operands reach the MAC only on accepted cycles; idle cycles drive zeros.
  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign mac_dataa[k*LANE_W +: LANE_W] = accept ? lane_get(in_dataa, k) : '0;
      assign mac_datab[k*LANE_W +: LANE_W] = accept ? lane_get(in_datab, k) : '0;
    end
  endgenerate

  mac_tag_pipe #(
    .DEPTH (MAC_LATENCY)
  ) u_tag_pipe (
    .clock  (clock),
    .reset  (reset),
    .push_i (accept),
    .tail_o (retire),
    .any_o  (in_flight)
  );

  // Next-state, accumulate-on-retire and result-release logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;

    if (retire) begin
      acc_d   = acc_q + ACC_W'(signed'(mac_result));
      count_d = count_q + CNT_W'(1);
    end

    case (state_q)
      ACCUM: begin
        if (accept && in_last) state_d = DRAIN;
      end
      // No tag in flight also means nothing retires this cycle.
      DRAIN: begin
        if (!in_flight) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State, accumulator and beat counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign out_result = acc_q;
  assign out_count  = count_q;
  assign busy       = (state_q != ACCUM) || in_flight;

endmodule

`default_nettype wire

// File: tb/tb_mac_dot_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mac_dot_sequencer
// Self-checking bench: directed groups plus randomized groups against a
// group-level dot-product reference; the MAC unit is modelled behaviourally.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mac_dot_sequencer;

  parameter int MAC_LATENCY = 3;
  localparam int ACC_W = 32;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_dataa = '0;
  logic [31:0]      in_datab = '0;
  logic             in_last = 1'b0;
  logic [31:0]      mac_dataa, mac_datab, mac_result;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_result;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  mac_dot_sequencer #(
    .MAC_LATENCY (MAC_LATENCY),
    .ACC_W       (ACC_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dataa   (in_dataa),
    .in_datab   (in_datab),
    .in_last    (in_last),
    .mac_dataa  (mac_dataa),
    .mac_datab  (mac_datab),
    .mac_result (mac_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_count  (out_count),
    .busy       (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Signed 4-lane dot product of two packed words.
  function automatic int dot4(input logic [31:0] a, input logic [31:0] b);
    int s;
    byte sa, sb;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      sa = a[8*k +: 8];
      sb = b[8*k +: 8];
      s = s + int'(sa) * int'(sb);
    end
    return s;
  endfunction

  function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  // Behavioural MAC unit: dot product delayed MAC_LATENCY cycles.
  logic [31:0] mac_pipe [MAC_LATENCY];
  always @(posedge clock) begin
    mac_pipe[0] <= dot4(mac_dataa, mac_datab);
    for (int i = 1; i < MAC_LATENCY; i++) mac_pipe[i] <= mac_pipe[i-1];
  end
  assign mac_result = mac_pipe[MAC_LATENCY-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got,
               $signed(exp), exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One accepted beat; also checks operand pass-through.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    in_valid = 1'b1;
    in_dataa = a;
    in_datab = b;
    in_last  = last;
    #1;
    check("beat_in_ready", in_ready, 1);
    check("beat_mac_a", mac_dataa, a);
    check("beat_mac_b", mac_datab, b);
    last_acc = cyc;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Idle cycle with junk data and a random in_last; operands must be zero.
  task automatic idle();
    in_valid = 1'b0;
    in_dataa = $urandom;
    in_datab = $urandom;
    in_last  = 1'($urandom);
    #1;
    check("idle_mac_a", mac_dataa, 0);
    check("idle_mac_b", mac_datab, 0);
    step();
    in_last = 1'b0;
  endtask

  // Wait for the group result, optionally stall, then handshake it.
  task automatic wait_result(input string nm, input int exp_sum, input int exp_cnt, input int hold);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      check({nm, "_drain_in_ready"}, in_ready, 0);
      check({nm, "_drain_busy"}, busy, 1);
      step();
      n++;
    end
    if (n >= 100) begin
      check({nm, "_timeout"}, 0, 1);
      return;
    end
    check({nm, "_latency"}, 64'(cyc - last_acc), 64'(MAC_LATENCY + 2));
    for (int h = 0; h < hold; h++) begin
      check({nm, "_hold_valid"}, out_valid, 1);
      check({nm, "_hold_result"}, out_result, 64'(exp_sum) & 64'hFFFF_FFFF);
      check({nm, "_hold_in_ready"}, in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check({nm, "_result"}, out_result, 64'(exp_sum) & 64'hFFFF_FFFF);
    check({nm, "_count"}, out_count, 64'(exp_cnt));
    check({nm, "_valid"}, out_valid, 1);
    step();
    out_ready = 1'b0;
    #1;
    check({nm, "_after_valid"}, out_valid, 0);
    check({nm, "_after_in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [31:0] a, b;
    int exp_sum, len;

    // Reset: ready low and operands gated even with in_valid high.
    in_valid = 1'b1;
    in_dataa = 32'h0102_0304;
    in_datab = 32'h0506_0708;
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_mac_a", mac_dataa, 0);
    check("rst_mac_b", mac_datab, 0);
    in_valid = 1'b0;
    reset = 1'b0;
    step();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_result", out_result, 0);
    check("post_rst_count", out_count, 0);

    // Single-beat group.
    send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1);
    wait_result("single", 70, 1, 0);

    // Three back-to-back beats of -128 x -128.
    for (int i = 0; i < 3; i++)
      send_beat(pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), i == 2);
    wait_result("neg128", 196608, 3, 0);

    // Mixed signs, two beats, stall output for 10 cycles.
    for (int i = 0; i < 2; i++)
      send_beat(pack4(127, -1, 0, -128), pack4(-128, 127, 5, 1), i == 1);
    wait_result("mixed", -33022, 2, 10);

    // Gapped beats at relative cycles 0,3,4,9.
    send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b0);
    idle(); idle();
    send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b0);
    send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b0);
    idle(); idle(); idle(); idle();
    send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b1);
    wait_result("gaps", 16, 4, 0);

    // Reset one cycle after the last beat: that group must vanish.
    send_beat(pack4(9, 9, 9, 9), pack4(9, 9, 9, 9), 1'b0);
    send_beat(pack4(9, 9, 9, 9), pack4(9, 9, 9, 9), 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < MAC_LATENCY + 6; i++) begin
      check("rst_drop_out_valid", out_valid, 0);
      check("rst_drop_busy", busy, 0);
      idle();
    end
    send_beat(pack4(2, 2, 2, 2), pack4(2, 2, 2, 2), 1'b1);
    wait_result("after_rst", 16, 1, 0);

    // Two consecutive groups in order.
    send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1);
    wait_result("pair0", 70, 1, 0);
    for (int i = 0; i < 2; i++)
      send_beat(pack4(127, -1, 0, -128), pack4(-128, 127, 5, 1), i == 1);
    wait_result("pair1", -33022, 2, 0);

    // Randomized groups against the group-level reference.
    for (int g = 0; g < 12; g++) begin
      len = int'($urandom_range(1, 6));
      exp_sum = 0;
      for (int i = 0; i < len; i++) begin
        for (int gap = int'($urandom_range(0, 2)); gap > 0; gap--) idle();
        a = $urandom;
        b = $urandom;
        exp_sum = exp_sum + dot4(a, b);
        send_beat(a, b, i == len - 1);
      end
      wait_result("rand", exp_sum, len, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
